// File: rtl/priority_arbitrator_hold.sv
// priority_arbitrator_hold
//   Registered one-hot arbiter for NUM_PORTS requesters. Each decision uses
//   either fixed priority (lowest index first) or round-robin, scanning upward
//   from a rotating pointer. A grant stays with its owner while the owner keeps
//   requesting. This keeps the grant stable for multi-cycle transfers.
//
//   Optional feature macro: PRIORITY_ARB_HOLD_LIMIT_EN
//     defined   -> a grant is released after MAX_HOLD consecutive cycles. On
//                  that release the holder loses to any other requester. A
//                  sole requester is re-granted with no gap.
//     undefined -> a grant is held for as long as the owner keeps requesting.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high
//   req_i        request vector, bit k = port k
//   mode_i       0 = fixed priority, 1 = round-robin (sampled on release only)
//   gnt_o        registered one-hot grant, or all-zero
//   gnt_valid_o  high when gnt_o is non-zero
//   gnt_id_o     index of the granted port; keeps its last value when idle
module priority_arbitrator_hold #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 mode_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [ID_W-1:0]      gnt_id_o
);

  if (NUM_PORTS < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("priority_arbitrator_hold: NUM_PORTS must be >= 2 and MAX_HOLD >= 1");
  end

  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;

  logic                 owner_req;
  logic                 limit_hit;
  logic                 release_en;
  logic [NUM_PORTS-1:0] cand;
  logic                 found;
  logic [ID_W-1:0]      win_id;

`ifdef PRIORITY_ARB_HOLD_LIMIT_EN
  localparam int              HC_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

  assign limit_hit = (hold_cnt_q == HOLD_LAST);
`else
  assign limit_hit = 1'b0;
`endif

  // With no current grant, owner_req is 0. That case releases as well.
  assign owner_req  = |(gnt_q & req_i);
  assign release_en = !owner_req || limit_hit;

  // At the hold limit, step the holder aside if anyone else wants the port.
  always_comb begin
    cand = req_i;
    if (limit_hit && |(req_i & ~gnt_q)) begin
      cand = req_i & ~gnt_q;
    end
  end

  // Winner search. Fixed mode scans from 0; round-robin mode scans from ptr_q
  // and wraps.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] sel;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mode_i) begin
        idx = (int'(ptr_q) + i) % NUM_PORTS;
      end else begin
        idx = i;
      end
      sel = ID_W'(idx);
      if (!found && cand[sel]) begin
        found  = 1'b1;
        win_id = sel;
      end
    end
  end

  always_comb begin
    gnt_d = gnt_q;
    id_d  = id_q;
    ptr_d = ptr_q;
`ifdef PRIORITY_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q + 1'b1;
`endif
    if (release_en) begin
`ifdef PRIORITY_ARB_HOLD_LIMIT_EN
      hold_cnt_d = '0;
`endif
      gnt_d = '0;
      if (found) begin
        // A sole requester re-granted at the limit gets the same one-hot value.
        // The grant output therefore shows no gap.
        gnt_d[win_id] = 1'b1;
        id_d          = win_id;
        ptr_d         = (int'(win_id) == NUM_PORTS - 1) ? '0 : win_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q <= '0;
      id_q  <= '0;
      ptr_q <= '0;
`ifdef PRIORITY_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      gnt_q <= gnt_d;
      id_q  <= id_d;
      ptr_q <= ptr_d;
`ifdef PRIORITY_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_id_o    = id_q;

endmodule

// File: tb/tb_priority_arbitrator_hold.sv
module tb_priority_arbitrator_hold;

  localparam int NP = 4;
  localparam int MH = 4;
`ifdef PRIORITY_ARB_HOLD_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          mode;
  logic [NP-1:0] req;
  logic [NP-1:0] gnt;
  logic          gnt_valid;
  logic [1:0]    gnt_id;

  int checks = 0;
  int errors = 0;

  // Reference model: the current owner index (-1 when idle), the round-robin
  // start point, the number of cycles the owner has already held, and the last
  // granted index.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_id    = 0;

  priority_arbitrator_hold #(
    .NUM_PORTS(NP),
    .MAX_HOLD (MH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .mode_i     (mode),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_step(input logic r, input logic m, input logic [NP-1:0] q);
    logic [NP-1:0] c;
    int            w;
    bit            keep;
    bit            at_limit;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_id    = 0;
      return;
    end
    keep     = (m_owner >= 0) && q[m_owner];
    at_limit = LIMIT_EN && (m_owner >= 0) && (m_held + 1 >= MH);
    if (keep && !at_limit) begin
      m_held++;
      return;
    end
    c = q;
    if (at_limit && keep && ((q & ~(4'(1) << m_owner)) != 0)) c[m_owner] = 1'b0;
    w = -1;
    for (int j = 0; j < NP; j++) begin
      int k;
      k = m ? (m_ptr + j) % NP : j;
      if (w < 0 && c[k]) w = k;
    end
    m_held = 0;
    if (w < 0) begin
      m_owner = -1;
    end else begin
      m_owner = w;
      m_id    = w;
      m_ptr   = (w + 1) % NP;
    end
  endtask

  task automatic step(input logic r, input logic m, input logic [NP-1:0] q);
    rst  = r;
    mode = m;
    req  = q;
    @(posedge clk);
    #1;
    model_step(r, m, q);
  endtask

  task automatic chk(input string name, input logic [NP-1:0] exp_gnt, input logic [1:0] exp_id);
    logic exp_v;
    exp_v = |exp_gnt;
    checks++;
    if (gnt !== exp_gnt || gnt_valid !== exp_v || gnt_id !== exp_id) begin
      errors++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
               name, gnt, gnt_valid, gnt_id, exp_gnt, exp_v, exp_id);
    end
  endtask

  task automatic chk_model(input string name);
    logic [NP-1:0] eg;
    eg = (m_owner >= 0) ? (4'(1) << m_owner) : 4'b0000;
    chk(name, eg, 2'(m_id));
  endtask

  typedef struct {
    logic          rst;
    logic          mode;
    logic [NP-1:0] req;
    logic [NP-1:0] gnt;
    logic [1:0]    id;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'b1110, 4'b0010, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 4'b0101, 4'b0100, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 2'd3};
    vecs[10] = '{1'b0, 1'b1, 4'b1001, 4'b1000, 2'd3};
    vecs[11] = '{1'b0, 1'b1, 4'b1001, 4'b1000, 2'd3};
    vecs[12] = '{1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0};
    vecs[13] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0};
    vecs[14] = '{1'b0, 1'b1, 4'b1001, 4'b0001, 2'd0};

    rst  = 1'b1;
    mode = 1'b0;
    req  = '0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].req);
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id);
    end

    if (!LIMIT_EN) begin
      // A fixed-priority grant is held for as long as its owner keeps requesting.
      step(1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b0, 4'b0110);
        chk($sformatf("fixed_hold%0d", i), 4'b0010, 2'd1);
      end
      step(1'b0, 1'b0, 4'b0100);
      chk("fixed_handover", 4'b0100, 2'd2);
      // Round-robin with all requesting: no rotation without the limit.
      step(1'b1, 1'b1, 4'b0000);
      for (int i = 0; i < 12; i++) begin
        step(1'b0, 1'b1, 4'b1111);
        chk($sformatf("rr_nolimit%0d", i), 4'b0001, 2'd0);
      end
    end else begin
      // Hold limit rotates contended grants every MH cycles.
      step(1'b1, 1'b1, 4'b0000);
      for (int i = 0; i < 17; i++) begin
        int k;
        logic [NP-1:0] eg;
        k  = (i / MH) % NP;
        eg = 4'(1) << k;
        step(1'b0, 1'b1, 4'b1111);
        chk($sformatf("rr_limit%0d", i), eg, 2'(k));
      end
      // A sole requester at the limit is re-granted with no drop cycle.
      step(1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 12; i++) begin
        step(1'b0, 1'b0, 4'b0100);
        chk($sformatf("sole%0d", i), 4'b0100, 2'd2);
      end
    end

    // Randomized traffic against the model. The owner's bit tends to stay high
    // so that grants are held.
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 600; i++) begin
      logic [NP-1:0] q;
      logic          r;
      logic          m;
      q = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) q[m_owner] = 1'b1;
      r = ($urandom_range(0, 49) == 0);
      m = 1'($urandom_range(0, 1));
      step(r, m, q);
      chk_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
